memory_cycle: RTL and testbench

- Memory (M) stage of the 5-stage RISC-V pipeline; the consumer of the E→M pipeline register outputs.
- Issues word loads and stores to an external data memory over a variable-latency req/ack handshake.
- Raises a stall to the hazard unit while an access is outstanding.
- Registers the M→W bundle: control, ALU result, read data, Rd, PC+4, error code.

---
 rtl/memory_cycle_if.sv | 27 ++
 rtl/memory_cycle.sv | 155 +++++++++++++++
 tb/tb_memory_cycle.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_if.sv
// Data-memory request/acknowledge bus between the M stage (master) and the data memory (slave).
interface memory_cycle_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_ack,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_ack,
      output dmem_rdata
   );
endinterface

// File: rtl/memory_cycle.sv
// RISC-V M stage: issues word loads/stores over a variable-latency req/ack bus,
// stalls the pipeline while an access is outstanding and registers the M->W bundle.
module memory_cycle #(
   parameter  int TIMEOUT = 16,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegWriteM,
   input  logic                 MemWriteM,
   input  logic [1:0]           ResultSrcM,
   input  logic [31:0]          ALUResultM,
   input  logic [31:0]          WriteDataM,
   input  logic [4:0]           RdM,
   input  logic [31:0]          PCPlus4M,
   memory_cycle_if.master       dmem,
   output logic                 StallM,
   output logic                 RegWriteW,
   output logic [1:0]           ResultSrcW,
   output logic [31:0]          ALUResultW,
   output logic [31:0]          ReadDataW,
   output logic [4:0]           RdW,
   output logic [31:0]          PCPlus4W,
   output logic [1:0]           ErrW
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [1:0]    ERR_NONE    = 2'b00;
   localparam logic [1:0]    ERR_MIS     = 2'b01;
   localparam logic [1:0]    ERR_TIMEOUT = 2'b10;
   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] CNT_LIMIT   = CW'(TIMEOUT);

   state_t        state_r;
   state_t        state_n_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_n_s;
   logic          load_s;
   logic          acc_s;
   logic          mis_s;
   logic          req_s;
   logic          stall_s;
   logic          take_s;
   logic          kill_s;
   logic [1:0]    err_s;
   logic [31:0]   rdata_s;

   assign load_s = (ResultSrcM == 2'b01);
   assign acc_s  = MemWriteM | load_s;
   assign mis_s  = acc_s & (ALUResultM[1:0] != 2'b00);

   // Next-state, request/stall decode and selection of what the W register captures.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      req_s     = 1'b0;
      stall_s   = 1'b0;
      take_s    = 1'b0;
      kill_s    = 1'b0;
      err_s     = ERR_NONE;
      rdata_s   = 32'h0000_0000;
      case (state_r)
         S_IDLE: begin
            if (acc_s && !mis_s) begin
               req_s = 1'b1;
               if (dmem.dmem_ack) begin
                  take_s  = 1'b1;
                  rdata_s = load_s ? dmem.dmem_rdata : 32'h0000_0000;
               end else begin
                  stall_s   = 1'b1;
                  cnt_n_s   = CNT_ONE;
                  state_n_s = S_WAIT;
               end
            end else if (mis_s) begin
               take_s = 1'b1;
               kill_s = 1'b1;
               err_s  = ERR_MIS;
            end else begin
               take_s = 1'b1;
            end
         end
         S_WAIT: begin
            // Upstream holds the M inputs stable while stalled, so they still describe this access.
            req_s = 1'b1;
            if (dmem.dmem_ack) begin
               take_s    = 1'b1;
               rdata_s   = load_s ? dmem.dmem_rdata : 32'h0000_0000;
               cnt_n_s   = CNT_ZERO;
               state_n_s = S_IDLE;
            end else if (cnt_r == CNT_LIMIT) begin
               take_s    = 1'b1;
               kill_s    = 1'b1;
               err_s     = ERR_TIMEOUT;
               cnt_n_s   = CNT_ZERO;
               state_n_s = S_IDLE;
            end else begin
               stall_s = 1'b1;
               cnt_n_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            cnt_n_s   = CNT_ZERO;
            state_n_s = S_IDLE;
         end
      endcase
   end

   // Reset gates the request so an abandoned access drops req immediately.
   assign dmem.dmem_req   = req_s & rst;
   assign dmem.dmem_we    = req_s & rst & MemWriteM;
   assign dmem.dmem_addr  = ALUResultM;
   assign dmem.dmem_wdata = WriteDataM;
   assign StallM          = stall_s & rst;

   // FSM state, wait counter and the M->W pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_IDLE;
         cnt_r      <= CNT_ZERO;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ALUResultW <= 32'h0000_0000;
         ReadDataW  <= 32'h0000_0000;
         RdW        <= 5'd0;
         PCPlus4W   <= 32'h0000_0000;
         ErrW       <= ERR_NONE;
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
         if (take_s) begin
            RegWriteW  <= RegWriteM & ~kill_s;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= rdata_s;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ErrW       <= err_s;
         end else begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'h0000_0000;
            ReadDataW  <= 32'h0000_0000;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'h0000_0000;
            ErrW       <= ERR_NONE;
         end
      end
   end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: per-cycle W expectations go through a scoreboard queue,
// request/stall behaviour is checked inline in each scenario task.
module tb_memory_cycle;

   localparam int TIMEOUT = 4;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [1:0]  err;
   } wexp_t;

   localparam wexp_t BUBBLE = '0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        StallM, RegWriteW;
   logic [1:0]  ResultSrcW, ErrW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;

   memory_cycle_if bus ();

   memory_cycle #(.TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .RdM        (RdM),
      .PCPlus4M   (PCPlus4M),
      .dmem       (bus),
      .StallM     (StallM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW),
      .PCPlus4W   (PCPlus4W),
      .ErrW       (ErrW)
   );

   always #5 clk = ~clk;

   int    cmp_cnt = 0;
   int    err_cnt = 0;
   wexp_t sb_q[$];

   function automatic wexp_t mk(input logic rw, input logic [1:0] rs, input logic [31:0] alu,
                                input logic [31:0] rdat, input logic [4:0] rd,
                                input logic [31:0] pc4, input logic [1:0] err);
      wexp_t w;
      w.rw = rw; w.rs = rs; w.alu = alu; w.rdat = rdat; w.rd = rd; w.pc4 = pc4; w.err = err;
      return w;
   endfunction

   task automatic set_m(input logic rw, input logic mw, input logic [1:0] rs, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4);
      RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
      ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
   endtask

   // Scoreboard: each entry pushed in a cycle is the W bundle expected after that cycle's edge.
   always @(negedge clk) begin
      wexp_t exp_w, act_w;
      if (sb_q.size() > 0) begin
         exp_w = sb_q.pop_front();
         act_w = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, ErrW};
         cmp_cnt++;
         if (act_w !== exp_w) begin
            err_cnt++;
            $display("FAIL w_bundle @%0t: got rw=%b rs=%b alu=%h rdata=%h rd=%0d pc4=%h err=%b, expected rw=%b rs=%b alu=%h rdata=%h rd=%0d pc4=%h err=%b",
                     $time, act_w.rw, act_w.rs, act_w.alu, act_w.rdat, act_w.rd, act_w.pc4, act_w.err,
                     exp_w.rw, exp_w.rs, exp_w.alu, exp_w.rdat, exp_w.rd, exp_w.pc4, exp_w.err);
         end
      end
   end

   task automatic test_reset();
      set_m(1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 5'd1, 32'h4);
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      #1 rst = 1'b0;
      #2;
      cmp_cnt++;
      if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, ErrW} !== 106'd0) begin
         err_cnt++;
         $display("FAIL reset_w: got rw=%b rs=%b alu=%h rdata=%h rd=%0d pc4=%h err=%b, expected all zero",
                  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, ErrW);
      end
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got req=%b stall=%b, expected req=0 stall=0", bus.dmem_req, StallM);
      end
      @(negedge clk); #1;
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
      rst = 1'b1;
   endtask

   task automatic test_passthrough();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         if (i == 0) begin
            set_m(1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h1111_1111, 5'd5, 32'h0000_1004);
            bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
         end else begin
            set_m(1'b1, 1'b0, 2'b10, 32'h0000_0ABC, 32'h0, 5'd0, 32'h0000_1008);
            bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h7777_7777;
         end
         #1;
         cmp_cnt++;
         if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
            err_cnt++;
            $display("FAIL pass_ctrl[%0d]: got req=%b stall=%b, expected req=0 stall=0", i, bus.dmem_req, StallM);
         end
         if (i == 0) sb_q.push_back(mk(1'b1, 2'b00, 32'h0000_0010, 32'h0, 5'd5, 32'h0000_1004, 2'b00));
         else        sb_q.push_back(mk(1'b1, 2'b10, 32'h0000_0ABC, 32'h0, 5'd0, 32'h0000_1008, 2'b00));
      end
   endtask

   task automatic test_zero_wait_load();
      @(negedge clk); #1;
      set_m(1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 5'd7, 32'h0000_2004);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h0000_0100 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL zw_load_ctrl: got req=%b we=%b addr=%h stall=%b, expected req=1 we=0 addr=00000100 stall=0",
                  bus.dmem_req, bus.dmem_we, bus.dmem_addr, StallM);
      end
      sb_q.push_back(mk(1'b1, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 32'h0000_2004, 2'b00));
   endtask

   task automatic test_store_3wait();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         set_m(1'b0, 1'b1, 2'b00, 32'h0000_0204, 32'h1234_5678, 5'd9, 32'h0000_3004);
         bus.dmem_ack = (i == 3); bus.dmem_rdata = 32'h0;
         #1;
         cmp_cnt++;
         if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h0000_0204 ||
             bus.dmem_wdata !== 32'h1234_5678 || StallM !== (i < 3)) begin
            err_cnt++;
            $display("FAIL store_ctrl[%0d]: got req=%b we=%b addr=%h wdata=%h stall=%b, expected req=1 we=1 addr=00000204 wdata=12345678 stall=%b",
                     i, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, StallM, (i < 3));
         end
         if (i < 3) sb_q.push_back(BUBBLE);
         else       sb_q.push_back(mk(1'b0, 2'b00, 32'h0000_0204, 32'h0, 5'd9, 32'h0000_3004, 2'b00));
      end
      @(negedge clk); #1;
      set_m(1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h0, 5'd2, 32'h0000_3008);
      bus.dmem_ack = 1'b0;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL store_idle: got req=%b stall=%b, expected req=0 stall=0", bus.dmem_req, StallM);
      end
      sb_q.push_back(mk(1'b0, 2'b00, 32'h0000_0040, 32'h0, 5'd2, 32'h0000_3008, 2'b00));
   endtask

   task automatic test_misaligned();
      @(negedge clk); #1;
      set_m(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd3, 32'h0000_4004);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL mis_ctrl: got req=%b stall=%b, expected req=0 stall=0", bus.dmem_req, StallM);
      end
      sb_q.push_back(mk(1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd3, 32'h0000_4004, 2'b01));
   endtask

   task automatic test_timeout(input logic ack_last);
      for (int i = 0; i <= TIMEOUT; i++) begin
         @(negedge clk); #1;
         set_m(1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd4, 32'h0000_5004);
         bus.dmem_ack = ack_last && (i == TIMEOUT); bus.dmem_rdata = 32'hCAFE_F00D;
         #1;
         cmp_cnt++;
         if (bus.dmem_req !== 1'b1 || StallM !== (i < TIMEOUT)) begin
            err_cnt++;
            $display("FAIL timeout_ctrl[ack=%b,%0d]: got req=%b stall=%b, expected req=1 stall=%b",
                     ack_last, i, bus.dmem_req, StallM, (i < TIMEOUT));
         end
         if (i < TIMEOUT)   sb_q.push_back(BUBBLE);
         else if (ack_last) sb_q.push_back(mk(1'b1, 2'b01, 32'h0000_0300, 32'hCAFE_F00D, 5'd4, 32'h0000_5004, 2'b00));
         else               sb_q.push_back(mk(1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd4, 32'h0000_5004, 2'b10));
      end
      @(negedge clk); #1;
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_5008);
      bus.dmem_ack = 1'b0;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_after[ack=%b]: got req=%b stall=%b, expected req=0 stall=0", ack_last, bus.dmem_req, StallM);
      end
      sb_q.push_back(mk(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_5008, 2'b00));
   endtask

   task automatic test_back_to_back();
      logic        mw_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ad_t [3] = '{32'h0000_0500, 32'h0000_0504, 32'h0000_0508};
      logic [31:0] rd_t [3] = '{32'h0102_0304, 32'h0, 32'hA5A5_5A5A};
      int          wt_t [3] = '{0, 0, 1};
      for (int e = 0; e < 3; e++) begin
         for (int w = 0; w <= wt_t[e]; w++) begin
            @(negedge clk); #1;
            set_m(~mw_t[e], mw_t[e], mw_t[e] ? 2'b00 : 2'b01, ad_t[e], 32'h0BAD_0000 + e, 5'(10 + e), 32'h0000_6000 + e);
            bus.dmem_ack = (w == wt_t[e]); bus.dmem_rdata = rd_t[e];
            #1;
            cmp_cnt++;
            if (bus.dmem_req !== 1'b1 || bus.dmem_we !== mw_t[e] || StallM !== (w < wt_t[e])) begin
               err_cnt++;
               $display("FAIL b2b_ctrl[%0d,%0d]: got req=%b we=%b stall=%b, expected req=1 we=%b stall=%b",
                        e, w, bus.dmem_req, bus.dmem_we, StallM, mw_t[e], (w < wt_t[e]));
            end
            if (w < wt_t[e]) sb_q.push_back(BUBBLE);
            else sb_q.push_back(mk(~mw_t[e], mw_t[e] ? 2'b00 : 2'b01, ad_t[e], rd_t[e], 5'(10 + e),
                                   32'h0000_6000 + e, 2'b00));
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         set_m(1'b1, 1'b0, 2'b01, 32'h0000_0400, 32'h0, 5'd6, 32'h0000_7004);
         bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
         #1;
         cmp_cnt++;
         if (bus.dmem_req !== 1'b1 || StallM !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_wait_ctrl[%0d]: got req=%b stall=%b, expected req=1 stall=1", i, bus.dmem_req, StallM);
         end
         if (i < 2) sb_q.push_back(BUBBLE);
      end
      rst = 1'b0;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0 || ALUResultW !== 32'h0 ||
          RdW !== 5'd0 || PCPlus4W !== 32'h0 || ErrW !== 2'b00 || ReadDataW !== 32'h0 || ResultSrcW !== 2'b00) begin
         err_cnt++;
         $display("FAIL rst_mid: got req=%b stall=%b rw=%b alu=%h rd=%0d pc4=%h err=%b, expected all zero",
                  bus.dmem_req, StallM, RegWriteW, ALUResultW, RdW, PCPlus4W, ErrW);
      end
      @(negedge clk); #1;
      set_m(1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0, 5'd8, 32'h0000_7008);
      rst = 1'b1;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_release: got req=%b stall=%b, expected req=0 stall=0", bus.dmem_req, StallM);
      end
      sb_q.push_back(mk(1'b1, 2'b00, 32'h0000_0020, 32'h0, 5'd8, 32'h0000_7008, 2'b00));
      @(negedge clk); #1;
      set_m(1'b1, 1'b0, 2'b01, 32'h0000_0410, 32'h0, 5'd12, 32'h0000_700C);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1357_9BDF;
      #1;
      cmp_cnt++;
      if (bus.dmem_req !== 1'b1 || StallM !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_next_load: got req=%b stall=%b, expected req=1 stall=0", bus.dmem_req, StallM);
      end
      sb_q.push_back(mk(1'b1, 2'b01, 32'h0000_0410, 32'h1357_9BDF, 5'd12, 32'h0000_700C, 2'b00));
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_zero_wait_load();
      test_store_3wait();
      test_misaligned();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_back_to_back();
      test_reset_mid_wait();
      @(negedge clk); #2;
      bus.dmem_ack = 1'b0;
      cmp_cnt++;
      if (sb_q.size() != 0) begin
         err_cnt++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
